checker_pulse_agg: RTL and testbench



---
 rtl/checker_pulse_agg.sv | 155 +++++++++++++++
 tb/tb_checker_pulse_agg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/checker_pulse_agg.sv
// Batches single-cycle event pulses and offers each batch count over valid/ready.
// Optional CHECKER_PULSE_AGG_TIMESTAMP_EN adds a first-pulse cycle timestamp (out_ts).
module checker_pulse_agg #(
    parameter int unsigned CW = 16,
    parameter int unsigned TW = 16
`ifdef CHECKER_PULSE_AGG_TIMESTAMP_EN
    ,
    parameter int unsigned TSW = 32
`endif
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          pulse_i,
    input  logic          enable,
    input  logic [CW-1:0] threshold,
    input  logic [TW-1:0] timeout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_ovf,
`ifdef CHECKER_PULSE_AGG_TIMESTAMP_EN
    output logic [TSW-1:0] out_ts,
`endif
    output logic          ovf_sticky,
    input  logic          ovf_clr
);

    typedef enum logic [1:0] {StIdle, StAccum, StOffer} state_e;

    localparam logic [CW-1:0] AccMax = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          bovf_q, bovf_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;
    logic          ovf_sticky_q, ovf_sticky_d;

    logic          acc_pulse;
    logic [CW-1:0] thr_eff;
    logic          close;
    logic          restart;
    logic          ovf_evt;

    assign acc_pulse = pulse_i & enable;
    assign thr_eff   = (threshold == '0) ? CW'(1) : threshold;
    assign close     = (acc_q != '0) &&
                       ((acc_q >= thr_eff) || ((timeout != '0) && (timer_q == timeout)) || !enable);
    // A batch is handed over when the slot is empty, or frees up at this very edge.
    assign restart   = close && ((state_q == StAccum) || ((state_q == StOffer) && out_ready));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        timer_d     = timer_q;
        bovf_d      = bovf_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        ovf_evt     = 1'b0;

        if (restart) begin
            out_valid_d = 1'b1;
            out_count_d = acc_q;
            out_ovf_d   = bovf_q;
            acc_d       = acc_pulse ? CW'(1) : '0;
            timer_d     = '0;
            bovf_d      = 1'b0;
            state_d     = StOffer;
        end else begin
            if (acc_pulse) begin
                if (acc_q == AccMax) begin
                    bovf_d  = 1'b1;
                    ovf_evt = 1'b1;
                end else begin
                    acc_d = acc_q + CW'(1);
                end
            end
            if (acc_q == '0) begin
                timer_d = '0;
            end else if (timer_q < timeout) begin
                timer_d = timer_q + TW'(1);
            end
            if (state_q != StOffer || out_ready) begin
                out_valid_d = 1'b0;
                state_d     = (acc_d != '0) ? StAccum : StIdle;
            end
        end

        ovf_sticky_d = ovf_evt | (ovf_sticky_q & ~ovf_clr);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            timer_q      <= '0;
            bovf_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            timer_q      <= timer_d;
            bovf_q       <= bovf_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
            out_ovf_q    <= out_ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_count  = out_count_q;
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = ovf_sticky_q;

`ifdef CHECKER_PULSE_AGG_TIMESTAMP_EN
    logic [TSW-1:0] ts_q, ts_d;
    logic [TSW-1:0] cap_q, cap_d;
    logic [TSW-1:0] out_ts_q, out_ts_d;

    always_comb begin
        ts_d     = ts_q + TSW'(1);
        cap_d    = cap_q;
        out_ts_d = out_ts_q;
        // First pulse of a batch: either into an empty accumulator or into a fresh one.
        if (acc_pulse && ((acc_q == '0) || restart)) begin
            cap_d = ts_q;
        end
        if (restart) begin
            out_ts_d = cap_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q     <= '0;
            cap_q    <= '0;
            out_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            cap_q    <= cap_d;
            out_ts_q <= out_ts_d;
        end
    end

    assign out_ts = out_ts_q;
`endif

endmodule

// File: tb/tb_checker_pulse_agg.sv
// Bench for checker_pulse_agg: directed cases with literal expectations plus randomized
// traffic compared every cycle against a batch/slot model of the aggregator.
module tb_checker_pulse_agg;

    localparam int unsigned CW  = 4;
    localparam int unsigned TW  = 8;
    localparam int          MAX = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          pulse_i = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] threshold = '0;
    logic [TW-1:0] timeout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          ovf_sticky;
    logic          ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Model: the open batch (count, age, overflow) and the output slot.
    int m_acc, m_age, m_bovf, m_valid, m_cnt, m_ovf, m_sticky;

    checker_pulse_agg #(.CW(CW), .TW(TW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pulse_i    (pulse_i),
        .enable     (enable),
        .threshold  (threshold),
        .timeout    (timeout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            m_acc = 0; m_age = 0; m_bovf = 0;
            m_valid = 0; m_cnt = 0; m_ovf = 0; m_sticky = 0;
        end else begin
            int  thr;
            int  nage;
            bit  acc_p, cl, xfer, ovf;
            acc_p = pulse_i && enable;
            thr   = (threshold == 0) ? 1 : int'(threshold);
            cl    = (m_acc != 0) &&
                    (m_acc >= thr || (timeout != 0 && m_age == int'(timeout)) || !enable);
            xfer  = (m_valid != 0) && out_ready;
            ovf   = 1'b0;
            if (cl && (m_valid == 0 || xfer)) begin
                m_valid = 1; m_cnt = m_acc; m_ovf = m_bovf;
                m_acc = acc_p ? 1 : 0; m_age = 0; m_bovf = 0;
            end else begin
                if (xfer) m_valid = 0;
                nage = (m_acc == 0) ? 0 : ((m_age < int'(timeout)) ? m_age + 1 : m_age);
                if (acc_p) begin
                    if (m_acc == MAX) begin
                        m_bovf = 1;
                        ovf = 1'b1;
                    end else begin
                        m_acc++;
                    end
                end
                m_age = nage;
            end
            if (ovf) m_sticky = 1;
            else if (ovf_clr) m_sticky = 0;
        end
    end

    initial forever begin
        @(negedge sys_clk);
        if (cmp_en) begin
            check("model_valid", out_valid, m_valid);
            if (m_valid != 0) begin
                check("model_count", out_count, m_cnt);
                check("model_ovf", out_ovf, m_ovf);
            end
            check("model_sticky", ovf_sticky, m_sticky);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        pulse_i   = 1'b0;
        ovf_clr   = 1'b0;
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int sum;
        int p;
        int rp;
        repeat (2) step();
        sys_rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset_valid", out_valid, 0);
        check("reset_count", out_count, 0);
        check("reset_ovf", out_ovf, 0);
        check("reset_sticky", ovf_sticky, 0);

        // Threshold close, consecutive pulses.
        do_reset();
        threshold = 4; timeout = 0; out_ready = 1; enable = 1;
        for (int i = 0; i < 4; i++) begin
            pulse_i = 1; step();
        end
        check("t1_not_yet", out_valid, 0);
        pulse_i = 0; step();
        check("t1_valid", out_valid, 1);
        check("t1_count", out_count, 4);
        check("t1_ovf", out_ovf, 0);
        step();
        check("t1_idle", out_valid, 0);

        // Timeout close, 11 cycles after the first pulse.
        do_reset();
        threshold = 15; timeout = 10; out_ready = 1; enable = 1;
        for (int i = 1; i <= 12; i++) begin
            pulse_i = (i == 1 || i == 4 || i == 7);
            step();
            if (i == 11) check("t2_early", out_valid, 0);
        end
        check("t2_valid", out_valid, 1);
        check("t2_count", out_count, 3);
        pulse_i = 0; step();

        // Backpressure: offer held stable, pulses keep counting.
        do_reset();
        threshold = 2; timeout = 0; out_ready = 0; enable = 1;
        for (int i = 1; i <= 25; i++) begin
            pulse_i = (i <= 9);
            step();
            if (i >= 3) begin
                check("t3_hold_valid", out_valid, 1);
                check("t3_hold_count", out_count, 2);
            end
        end
        out_ready = 1; step();
        check("t3_b2b_valid", out_valid, 1);
        check("t3_b2b_count", out_count, 7);
        step();
        check("t3_drained", out_valid, 0);

        // Saturation during an offer, sticky flag and its clear.
        do_reset();
        threshold = 15; timeout = 0; out_ready = 0; enable = 1;
        for (int i = 1; i <= 33; i++) begin
            pulse_i = 1; step();
            if (i == 16) begin
                check("t4_first_count", out_count, 15);
                check("t4_first_ovf", out_ovf, 0);
            end
        end
        pulse_i = 0; out_ready = 1; step();
        check("t4_second_count", out_count, 15);
        check("t4_second_ovf", out_ovf, 1);
        check("t4_sticky_set", ovf_sticky, 1);
        step();
        check("t4_drained", out_valid, 0);
        out_ready = 0; ovf_clr = 1; step();
        ovf_clr = 0;
        check("t4_sticky_clr", ovf_sticky, 0);

        // Threshold 1 with sustained pulses: continuous back-to-back offers.
        do_reset();
        threshold = 1; timeout = 0; out_ready = 1; enable = 1;
        sum = 0;
        for (int i = 1; i <= 22; i++) begin
            pulse_i = (i <= 20);
            step();
            if (i >= 2 && i <= 21) begin
                check("t5_valid", out_valid, 1);
                if (out_valid) sum += int'(out_count);
            end
        end
        check("t5_idle", out_valid, 0);
        check("t5_sum", sum, 20);

        // Reset during an offer with a partly full batch.
        do_reset();
        threshold = 2; timeout = 0; out_ready = 0; enable = 1;
        for (int i = 0; i < 7; i++) begin
            pulse_i = 1; step();
        end
        pulse_i = 0; step(); step();
        check("t6_offer", out_valid, 1);
        #1 sys_rst_n = 0;
        #1 check("t6_async_drop", out_valid, 0);
        step();
        sys_rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_no_offer", out_valid, 0);
        end

        // Randomized traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            threshold = CW'($urandom_range(0, MAX));
            timeout   = TW'($urandom_range(0, 12));
            p  = $urandom_range(10, 95);
            rp = $urandom_range(5, 95);
            for (int c = 0; c < 500; c++) begin
                pulse_i   = ($urandom_range(0, 99) < p);
                enable    = ($urandom_range(0, 19) != 0);
                out_ready = ($urandom_range(0, 99) < rp);
                ovf_clr   = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 49) == 0) threshold = CW'($urandom_range(0, MAX));
                if (seg == 3 && c == 250) begin
                    sys_rst_n = 0;
                    step();
                    sys_rst_n = 1;
                end
                step();
            end
        end

        pulse_i = 0; ovf_clr = 0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
